// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM encoding and default operand width.
package serial_subtractor_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - b_in, with borrow out.
module full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic b_i,
  output logic d_o,
  output logic b_o
);

  assign d_o = x_i ^ y_i ^ b_i;
  assign b_o = (~x_i & y_i) | (~(x_i ^ y_i) & b_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first; result valid WIDTH edges after accept.
// Holds the result in DONE until out_ready; operands are ignored outside IDLE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovld_q, ovld_d;

  logic x_bit, y_bit, cell_d, cell_b;

  full_subtractor u_cell (
    .x_i (x_bit),
    .y_i (y_bit),
    .b_i (borrow_q),
    .d_o (cell_d),
    .b_o (cell_b)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    d_d      = d_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovld_d   = ovld_q;
    x_bit    = 1'b0;
    y_bit    = 1'b0;

    // Mux-select the active bit by comparing the counter, so no index is wider than the vector.
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == CW'(i)) begin
        x_bit = x_q[i];
        y_bit = y_q[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d      = x;
          y_d      = y;
          borrow_d = b_in;
          cnt_d    = '0;
          d_d      = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CW'(i)) d_d[i] = cell_d;
        end
        borrow_d = cell_b;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = d_d;
          bout_d  = cell_b;
          ovld_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ovld_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      d_q      <= d_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovld_q   <= ovld_d;
    end
  end

  // d/b_out come from a separate result register so they keep the last result during the next RUN.
  assign in_ready  = ~rst & (state_q == ST_IDLE);
  assign out_valid = ovld_q;
  assign d         = res_q;
  assign b_out     = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised scoreboard bench for serial_subtractor against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         b_out;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .b_out     (b_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random stalls, 2: held low

  int exp_q[$];      // {b_out, d} expected per accepted operand set
  int acc_q[$];      // cycle number of each accepting edge

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_model(input int xv, input int yv, input int bv);
    int diff;
    diff = xv - yv - bv;
    return (((diff < 0) ? 1 : 0) << W) | (diff & ((1 << W) - 1));
  endfunction

  // Monitor: compares every output handshake with the scoreboard head.
  bit prev_ov  = 1'b0;
  bit prev_rdy = 1'b0;
  int prev_res = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov && acc_q.size() > 0)
        check("latency", cyc - acc_q.pop_front(), W);
      if (prev_ov && !prev_rdy && out_valid)
        check("hold_stable", {b_out, d}, prev_res);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("result", {b_out, d}, exp_q.pop_front());
      end
      prev_ov  = out_valid;
      prev_rdy = out_ready;
      prev_res = {b_out, d};
    end
  end

  task automatic send(input int xv, input int yv, input int bv, input bit disturb);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    x = W'(xv);
    y = W'(yv);
    b_in = bv[0];
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(ref_model(xv, yv, bv));
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    if (disturb) begin
      repeat (W - 1) begin
        x = W'($urandom);
        y = W'($urandom);
        b_in = $urandom_range(0, 1) != 0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    b_in = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
    check("rst_b_out", b_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // 7-3: latency, then IDLE one edge after the handshake.
    send(7, 3, 0, 0);
    wait_ov();
    check("t1_in_ready_in_done", in_ready, 0);
    check("t1_d", d, 4);
    check("t1_b_out", b_out, 0);
    @(negedge clk);
    check("t1_out_valid_cleared", out_valid, 0);
    check("t1_in_ready_back", in_ready, 1);

    send(3, 7, 0, 0);
    send(0, 0, 1, 0);
    send(15, 15, 1, 0);
    drain();

    // Backpressure: result held for 5 stalled cycles, then one transfer.
    rdy_mode = 2;
    @(negedge clk);
    send(9, 2, 0, 0);
    wait_ov();
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_d", d, 7);
      check("bp_b_out", b_out, 0);
    end
    rdy_mode = 0;
    drain();
    @(negedge clk);
    check("bp_single_transfer", out_valid, 0);

    // Operand disturbance during RUN must not leak into the result.
    send(12, 5, 1, 1);
    send(1, 14, 0, 1);
    drain();

    // Reset mid-RUN abandons the transaction.
    send(11, 6, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_d", d, 0);
    check("mid_rst_b_out", b_out, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    highs = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    check("post_rst_no_valid", highs, 0);
    send(5, 5, 0, 0);
    drain();

    // Every operand combination with random consumer stalls.
    rdy_mode = 1;
    for (int xi = 0; xi < (1 << W); xi++)
      for (int yi = 0; yi < (1 << W); yi++)
        for (int bi = 0; bi < 2; bi++)
          send(xi, yi, bi, $urandom_range(0, 3) == 0);
    drain();
    check("latency_queue_empty", acc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
